// File: rtl/int_cvt_pack_buf.sv
// int_cvt_pack_buf: collects converter results and packs 16-bit halves into
// 32-bit words. Packed words wait in a small FIFO with a half-word enable
// mask. Both sides use valid/ready handshakes.
//
// state | meaning
// IDLE  | no half-word held; 32-bit results pass straight to the FIFO
// HALF  | one half-word held in the merge register, waiting for its partner
module int_cvt_pack_buf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_prec,
  input  logic             in_pos,
  input  logic             flush,
  output logic             out_vld,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_mask,
  output logic             pend,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       held_data, held_data_nxt;
  logic              held_pos, held_pos_nxt;
  logic              rdy_en;

  logic [31:0]       mem_data [DEPTH];
  logic [1:0]        mem_mask [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              full;
  logic              conflict;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       push_data;
  logic [1:0]        push_mask;
  logic [31:0]       pend_word;
  logic [1:0]        pend_mask;

  // Space is judged on the registered count only; a pop in the same cycle
  // does not open a slot for the input.
  assign full     = (count == CNT_W'(DEPTH));
  assign pend     = (state == HALF);
  assign conflict = pend && in_vld && (in_prec || (in_pos == held_pos));
  assign in_ready = rdy_en && !full && !conflict;
  assign accept   = in_vld && in_ready;

  assign out_vld  = (count != '0);
  assign pop      = out_vld && out_ready;
  assign out_data = out_vld ? mem_data[rd_ptr] : 32'h0;
  assign out_mask = out_vld ? mem_mask[rd_ptr] : 2'b00;

  assign pend_word = held_pos ? {held_data, 16'h0000} : {16'h0000, held_data};
  assign pend_mask = held_pos ? 2'b10 : 2'b01;

  // Holds in_ready low while in reset and releases it one clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Merge state and the held half-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      held_data <= 16'h0000;
      held_pos  <= 1'b0;
    end else begin
      state     <= state_nxt;
      held_data <= held_data_nxt;
      held_pos  <= held_pos_nxt;
    end
  end

  // Next merge state and the FIFO push request. A conflicting input forces
  // the held half out first, which costs one bubble on the input side.
  always_comb begin
    state_nxt     = state;
    held_data_nxt = held_data;
    held_pos_nxt  = held_pos;
    push          = 1'b0;
    push_data     = 32'h0;
    push_mask     = 2'b00;
    unique case (state)
      IDLE: begin
        if (accept && in_prec) begin
          push      = 1'b1;
          push_data = in_data;
          push_mask = 2'b11;
        end else if (accept) begin
          held_data_nxt = in_pos ? in_data[31:16] : in_data[15:0];
          held_pos_nxt  = in_pos;
          state_nxt     = HALF;
        end
      end
      HALF: begin
        if (accept) begin
          push      = 1'b1;
          push_data = in_pos ? {in_data[31:16], held_data} : {held_data, in_data[15:0]};
          push_mask = 2'b11;
          state_nxt = IDLE;
        end else if ((conflict || flush) && !full) begin
          push      = 1'b1;
          push_data = pend_word;
          push_mask = pend_mask;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy; reset clears everything so no
  // stale word can reappear afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= 32'h0;
        mem_mask[i] <= 2'b00;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_mask[wr_ptr] <= push_mask;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_int_cvt_pack_buf.sv
// Randomized and directed bench for int_cvt_pack_buf against a queue-based
// reference model of the packing rules.
module tb_int_cvt_pack_buf;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'h0;
  logic             in_prec = 1'b0;
  logic             in_pos = 1'b0;
  logic             flush = 1'b0;
  logic             out_vld;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [1:0]       out_mask;
  logic             pend;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [33:0] q[$];
  bit          m_pend = 0;
  logic [15:0] m_held = 16'h0;
  bit          m_hpos = 0;
  bit          m_alive = 0;

  int_cvt_pack_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_ready(in_ready), .in_data(in_data),
    .in_prec(in_prec), .in_pos(in_pos), .flush(flush),
    .out_vld(out_vld), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .pend(pend), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, compare outputs
  // against the model, then advance the model to match the coming rising edge.
  task automatic step(input bit v, input logic [31:0] d, input bit p, input bit ps,
                      input bit f, input bit r);
    bit full_m, confl, exp_rdy, acc, pop_m, push_m;
    logic [33:0] pw;
    @(negedge clk);
    in_vld = v; in_data = d; in_prec = p; in_pos = ps; flush = f; out_ready = r;
    #1;
    full_m  = (q.size() == DEPTH);
    confl   = m_pend && v && (p || (ps == m_hpos));
    exp_rdy = m_alive && !full_m && !confl;
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_val("out_vld", 32'(out_vld), 32'(q.size() > 0));
    check_val("out_data", out_data, (q.size() > 0) ? q[0][33:2] : 32'h0);
    check_val("out_mask", 32'(out_mask), (q.size() > 0) ? 32'(q[0][1:0]) : 32'h0);
    check_val("pend", 32'(pend), 32'(m_pend));
    check_val("count", 32'(count), 32'(q.size()));

    acc    = v && exp_rdy;
    pop_m  = (q.size() > 0) && r;
    push_m = 0;
    pw     = '0;
    if (!m_pend) begin
      if (acc && p) begin
        push_m = 1; pw = {d, 2'b11};
      end else if (acc) begin
        m_pend = 1; m_hpos = ps; m_held = ps ? d[31:16] : d[15:0];
      end
    end else begin
      if (acc) begin
        push_m = 1;
        pw = ps ? {d[31:16], m_held, 2'b11} : {m_held, d[15:0], 2'b11};
        m_pend = 0;
      end else if ((confl || f) && !full_m) begin
        push_m = 1;
        pw = m_hpos ? {m_held, 16'h0, 2'b10} : {16'h0, m_held, 2'b01};
        m_pend = 0;
      end
    end
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(pw);
  endtask

  task automatic idle(input bit r);
    step(0, 32'h0, 0, 0, 0, r);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_vld", 32'(out_vld), 32'h0);
    check_val("rst_count", 32'(count), 32'h0);
    check_val("rst_pend", 32'(pend), 32'h0);
    check_val("rst_in_ready", 32'(in_ready), 32'h0);
    q.delete();
    m_pend = 0; m_alive = 0;
    in_vld = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    m_alive = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_val("init_in_ready", 32'(in_ready), 32'h0);
    check_val("init_out_vld", 32'(out_vld), 32'h0);
    check_val("init_out_data", out_data, 32'h0);
    check_val("init_out_mask", 32'(out_mask), 32'h0);
    check_val("init_pend", 32'(pend), 32'h0);
    check_val("init_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    m_alive = 1;

    // 32-bit passthrough
    step(1, 32'h7FFFFFFF, 1, 0, 0, 0);
    idle(0);
    check_val("pt_vld", 32'(out_vld), 32'h1);
    check_val("pt_data", out_data, 32'h7FFFFFFF);
    check_val("pt_mask", 32'(out_mask), 32'h3);
    check_val("pt_count", 32'(count), 32'h1);
    idle(1); idle(0);

    // half merge
    step(1, 32'h00008000, 0, 0, 0, 0);
    step(1, 32'h7FFF0000, 0, 1, 0, 0);
    check_val("merge_pend_mid", 32'(pend), 32'h1);
    idle(0);
    check_val("merge_pend_after", 32'(pend), 32'h0);
    check_val("merge_data", out_data, 32'h7FFF8000);
    check_val("merge_mask", 32'(out_mask), 32'h3);
    check_val("merge_count", 32'(count), 32'h1);
    idle(1); idle(0);

    // same-position conflict: one bubble, then flush the second half
    step(1, 32'h00000001, 0, 0, 0, 0);
    step(1, 32'h0000FFFF, 0, 0, 0, 0);
    check_val("confl_bubble", 32'(in_ready), 32'h0);
    step(1, 32'h0000FFFF, 0, 0, 0, 0);
    check_val("confl_retry", 32'(in_ready), 32'h1);
    idle(0);
    check_val("confl_head", out_data, 32'h00000001);
    check_val("confl_mask", 32'(out_mask), 32'h1);
    step(0, 32'h0, 0, 0, 1, 0);
    idle(1);
    check_val("confl_count2", 32'(count), 32'h2);
    idle(1);
    check_val("confl_head2", out_data, 32'h0000FFFF);
    check_val("confl_mask2", 32'(out_mask), 32'h1);
    idle(0);

    // flush of a high half
    step(1, 32'h12340000, 0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 1, 0);
    idle(0);
    check_val("fl_data", out_data, 32'h12340000);
    check_val("fl_mask", 32'(out_mask), 32'h2);
    check_val("fl_pend", 32'(pend), 32'h0);
    idle(1); idle(0);

    // backpressure to full, then drain across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 32'hA000_0000 + 32'(i), 1, 0, 0, 0);
    idle(0);
    check_val("full_count", 32'(count), 32'h4);
    step(1, 32'hA000_0004, 1, 0, 0, 0);
    check_val("full_in_ready", 32'(in_ready), 32'h0);
    step(1, 32'hA000_0004, 1, 0, 0, 1);
    check_val("full_still_blocked", 32'(in_ready), 32'h0);
    step(1, 32'hA000_0004, 1, 0, 0, 1);
    check_val("full_reopen", 32'(in_ready), 32'h1);
    for (int i = 5; i < 10; i++) step(1, 32'hA000_0000 + 32'(i), 1, 0, 0, 1);
    repeat (12) idle(1);

    // reset with content queued and a half pending
    for (int i = 0; i < 3; i++) step(1, 32'hB000_0000 + 32'(i), 1, 0, 0, 0);
    step(1, 32'h0000_5A5A, 0, 0, 0, 0);
    idle(0);
    mid_reset();
    repeat (4) idle(1);
    check_val("post_rst_vld", 32'(out_vld), 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1);
    end
    step(0, 32'h0, 0, 0, 1, 1);
    repeat (8) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
